// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage. Owns the PC, reads instruction memory over a
//               req/ack handshake and holds the fetched word in a registered
//               instruction latch that feeds decode (split fields, imm16).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o
);

  localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        fetch_done;
  logic        consume;

  // A live instruction that decode is stalling on must not be overwritten,
  // so the request is withheld in that case even while in REQ.
  assign imem_req_o  = (state == REQ) && !(stall_i && instr_valid_o);
  assign imem_addr_o = pc & C_WORD_MASK;

  // An ack only counts when a request was actually outstanding.
  assign fetch_done = imem_req_o && imem_ack_i;
  assign consume    = instr_valid_o && !stall_i;

  assign pc_plus4_o = pc_o + PC_STEP;
  assign opcode_o   = instr_o[31:26];
  assign rs_o       = instr_o[25:21];
  assign rt_o       = instr_o[20:16];
  assign rd_o       = instr_o[15:11];
  assign funct_o    = instr_o[5:0];
  assign imm16_o    = instr_o[15:0];

  // Fetch state machine, PC and instruction latch; redirect overrides all.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      pc            <= RESET_PC & C_WORD_MASK;
      instr_valid_o <= 1'b0;
      instr_o       <= 32'h0000_0000;
      pc_o          <= RESET_PC;
    end else if (redirect_i) begin
      // Any ack arriving this cycle belongs to the abandoned path.
      pc            <= redirect_pc_i & C_WORD_MASK;
      instr_valid_o <= 1'b0;
      state         <= REQ;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (fetch_done) begin
            instr_o       <= imem_data_i;
            pc_o          <= pc;
            instr_valid_o <= 1'b1;
            pc            <= pc + PC_STEP;
            if (stall_i) begin
              state <= HOLD;
            end
          end else if (consume) begin
            instr_valid_o <= 1'b0;
          end
        end
        HOLD: begin
          // Leaving HOLD is the cycle decode takes the held instruction.
          if (!stall_i) begin
            state         <= REQ;
            instr_valid_o <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit against a
//               program-order reference model with a variable-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_data, instr, pc_out, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  // second instance: wrap-around reset PC, zero-wait memory, never stalled
  logic        req2, valid2;
  logic [31:0] addr2, data2, instr2, pc2, pc4_2;
  logic [5:0]  opcode2, funct2;
  logic [4:0]  rs2, rt2, rd2;
  logic [15:0] imm2;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model and reference-model state
  int          wait_left = 0;
  int          min_lat   = 0;
  int          max_lat   = 0;
  logic        started   = 1'b0;
  logic        held      = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_pc    = 32'h0;
  logic [31:0] exp_fetch = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_8004;
    return (a * 32'h0001_0003) ^ 32'h5A5A_1234;
  endfunction

  assign imem_ack  = imem_req && (wait_left == 0);
  assign imem_data = word(imem_addr);
  assign data2     = word(addr2);

  instr_fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc_out),
    .pc_plus4_o(pc_plus4), .opcode_o(opcode), .rs_o(rs), .rt_o(rt),
    .rd_o(rd), .funct_o(funct), .imm16_o(imm16)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(req2), .imem_data_i(data2),
    .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(valid2), .instr_o(instr2), .pc_o(pc2),
    .pc_plus4_o(pc4_2), .opcode_o(opcode2), .rs_o(rs2), .rt_o(rt2),
    .rd_o(rd2), .funct_o(funct2), .imm16_o(imm2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_latency();
    return int'($urandom_range(max_lat, min_lat));
  endfunction

  task automatic model_reset();
    started   = 1'b0;
    held      = 1'b0;
    exp_valid = 1'b0;
    exp_fetch = 32'h0;
    exp_pc    = 32'h0;
    wait_left = 0;
  endtask

  // One clock cycle: entered at a falling edge, returns at the next one.
  task automatic step(input logic st, input logic rd_in, input logic [31:0] rpc);
    logic        exp_req, acked, consumed, req_now;
    logic [31:0] w;
    stall = st; redirect = rd_in; redirect_pc = rpc;
    #1;
    exp_req = started && !held && !(st && exp_valid);
    check("req", {31'b0, imem_req}, {31'b0, exp_req});
    check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
    if (exp_req) check("addr", imem_addr, exp_fetch);
    check("valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      w = word(exp_pc);
      check("pc", pc_out, exp_pc);
      check("instr", instr, w);
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
      check("fields", {5'b0, opcode, rs, rt, rd, funct},
            {5'b0, w[31:26], w[25:21], w[20:16], w[15:11], w[5:0]});
      check("imm16", {16'b0, imm16}, {16'b0, w[15:0]});
    end
    req_now  = imem_req;
    acked    = imem_req && imem_ack;
    consumed = exp_valid && !st;
    @(posedge clk);
    #1;
    if (rd_in) begin
      exp_valid = 1'b0;
      exp_fetch = rpc & 32'hFFFF_FFFC;
      held      = 1'b0;
      started   = 1'b1;
    end else if (!started) begin
      started = 1'b1;
    end else if (acked) begin
      exp_valid = 1'b1;
      exp_pc    = exp_fetch;
      exp_fetch = exp_fetch + 32'd4;
      held      = st;
    end else begin
      if (consumed) exp_valid = 1'b0;
      if (!st) held = 1'b0;
    end
    if (acked || rd_in) wait_left = pick_latency();
    else if (req_now && wait_left > 0) wait_left--;
    @(negedge clk);
  endtask

  // Wrap-around instance: addresses step FFFF_FFF8, FFFF_FFFC, 0000_0000.
  initial begin
    @(negedge rst);
    @(negedge clk); #2;
    check("wrap_addr0", addr2, 32'hFFFF_FFF8);
    check("wrap_req0", {31'b0, req2}, 32'h1);
    @(negedge clk); #2;
    check("wrap_addr1", addr2, 32'hFFFF_FFFC);
    @(negedge clk); #2;
    check("wrap_addr2", addr2, 32'h0000_0000);
    check("wrap_pc_o", pc2, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc4_2, 32'h0000_0000);
    check("wrap_instr", instr2, word(32'hFFFF_FFFC));
  end

  initial begin
    // reset state
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_o", pc_out, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_fields", {opcode, rs, rt, rd, funct, imm16[9:0]}, 32'h0);
    model_reset();
    rst = 1'b0;

    // zero-wait sequential fetch
    min_lat = 0; max_lat = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

    // stall for four cycles then resume
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // redirect coincident with an ack
    step(1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);

    // three-cycle memory, target holding 32'h2008_8004
    min_lat = 3; max_lat = 3;
    step(1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 10; i++) begin
      if (exp_valid && exp_pc == 32'h40)
        check("imm16_8004", {16'b0, imm16}, 32'h0000_8004);
      step(1'b0, 1'b0, 32'h0);
    end

    // asynchronous reset while a request waits for its ack
    step(1'b0, 1'b1, 32'h0000_0300);
    wait_left = 5;
    step(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_valid", {31'b0, instr_valid}, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_pc_o", pc_out, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    @(negedge clk);
    model_reset();
    min_lat = 0; max_lat = 0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);

    // randomized stall / redirect / latency
    min_lat = 0; max_lat = 3;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
